vram_write_buffer: RTL and testbench

- Elastic write buffer between the rasteriser's fire-and-forget VRAM write strobes and the VRAM/SDRAM controller port, which acknowledges writes.
- Each cycle with sel&wr high captures {mask, addr, data} into a FIFO. The FIFO drains to the memory port with a hold-until-ack handshake, so producer bursts (CLEAR, triangle fill) survive memory stalls.
- Loss on overflow is reported by a sticky flag; the block never back-pressures the producer.

---
 rtl/vram_write_buffer.sv | 127 ++++++++++++
 tb/tb_vram_write_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_buffer.sv
// Elastic FIFO between fire-and-forget VRAM write strobes and an acknowledging memory port.
// Head entry is held in an output register until acked. The producer is never stalled, and drops set a sticky flag.
module vram_write_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    vram_sel_i,
    input  logic                    vram_wr_i,
    input  logic [3:0]              vram_mask_i,
    input  logic [ADDR_WIDTH-1:0]   vram_addr_i,
    input  logic [DATA_WIDTH-1:0]   vram_data_i,
    input  logic                    clear_overflow_i,
    output logic                    mem_sel_o,
    output logic                    mem_wr_o,
    output logic [3:0]              mem_mask_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    input  logic                    mem_ack_i,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [3:0]            mask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    entry_t          ram_q [DEPTH];
    state_t          state_q, state_d;
    entry_t          head_q, head_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic            push, pop, accept, drop;
    entry_t          in_entry;

    assign in_entry = {vram_mask_i, vram_addr_i, vram_data_i};

    always_comb begin
        push     = vram_sel_i & vram_wr_i;
        pop      = (state_q == ISSUE) & mem_ack_i;
        // At full, a push is still accepted when the head retires on the same edge.
        accept   = push & ((level_q != FULL_LVL) | pop);
        drop     = push & ~accept;
        state_d  = state_q;
        head_d   = head_q;
        wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (accept && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !accept) begin
            level_d = level_q - LW'(1);
        end
        ovf_d = drop | (ovf_q & ~clear_overflow_i);

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    state_d = ISSUE;
                    head_d  = ram_q[rd_ptr_q];
                end
            end
            ISSUE: begin
                if (pop) begin
                    if (level_q > LW'(1)) begin
                        head_d = ram_q[rd_ptr_d];
                    end else if (accept) begin
                        // Sole follower is being written this edge, so forward it from the input.
                        head_d = in_entry;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ram_q[wr_ptr_q] <= in_entry;
        end
    end

    assign mem_sel_o  = (state_q == ISSUE);
    assign mem_wr_o   = mem_sel_o;
    assign mem_mask_o = head_q.mask;
    assign mem_addr_o = head_q.addr;
    assign mem_data_o = head_q.data;
    assign level_o    = level_q;
    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == FULL_LVL);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_vram_write_buffer.sv
// Directed bench for vram_write_buffer with DEPTH=16, 16-bit address and data.
module tb_vram_write_buffer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        vram_sel_i, vram_wr_i;
    logic [3:0]  vram_mask_i;
    logic [15:0] vram_addr_i, vram_data_i;
    logic        clear_overflow_i;
    logic        mem_sel_o, mem_wr_o;
    logic [3:0]  mem_mask_o;
    logic [15:0] mem_addr_o, mem_data_o;
    logic        mem_ack_i;
    logic        empty_o, full_o, overflow_o;
    logic [4:0]  level_o;

    int checks = 0;
    int errors = 0;
    int maxlvl;

    vram_write_buffer #(.DEPTH(16), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset_i(reset_i),
        .vram_sel_i(vram_sel_i), .vram_wr_i(vram_wr_i), .vram_mask_i(vram_mask_i),
        .vram_addr_i(vram_addr_i), .vram_data_i(vram_data_i),
        .clear_overflow_i(clear_overflow_i),
        .mem_sel_o(mem_sel_o), .mem_wr_o(mem_wr_o), .mem_mask_o(mem_mask_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i),
        .empty_o(empty_o), .full_o(full_o), .level_o(level_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic en, input logic [15:0] a, input logic [15:0] d, input logic [3:0] m);
        vram_sel_i  = en;
        vram_wr_i   = en;
        vram_addr_i = a;
        vram_data_i = d;
        vram_mask_i = m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        clear_overflow_i = 1'b0;
        mem_ack_i = 1'b0;
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        #2;
        chk("rst_sel",   32'(mem_sel_o), 32'd0);
        chk("rst_wr",    32'(mem_wr_o), 32'd0);
        chk("rst_mask",  32'(mem_mask_o), 32'd0);
        chk("rst_addr",  32'(mem_addr_o), 32'd0);
        chk("rst_data",  32'(mem_data_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full",  32'(full_o), 32'd0);
        chk("rst_ovf",   32'(overflow_o), 32'd0);
        tick();
        reset_i = 1'b0;

        // Single write, ack tied high
        mem_ack_i = 1'b1;
        wr(1'b1, 16'h0010, 16'hF123, 4'hF);
        tick();
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        chk("single_lvl_cap", 32'(level_o), 32'd1);
        chk("single_sel_cap", 32'(mem_sel_o), 32'd0);
        tick();
        chk("single_sel",  32'({mem_sel_o, mem_wr_o}), 32'b11);
        chk("single_addr", 32'(mem_addr_o), 32'h0010);
        chk("single_data", 32'(mem_data_o), 32'hF123);
        chk("single_mask", 32'(mem_mask_o), 32'hF);
        chk("single_lvl",  32'(level_o), 32'd1);
        tick();
        chk("single_done_sel", 32'(mem_sel_o), 32'd0);
        chk("single_done_lvl", 32'(level_o), 32'd0);
        chk("single_empty",    32'(empty_o), 32'd1);

        // Long burst under continuous ack: one write per cycle after the first
        maxlvl = 0;
        for (int i = 0; i < 16384; i++) begin
            wr(1'b1, 16'(i), 16'hF00F, 4'hF);
            tick();
            if (int'(level_o) > maxlvl) maxlvl = int'(level_o);
            if (i == 0) chk("burst_first_gap", 32'(mem_sel_o), 32'd0);
            else        chk("burst_addr", 32'({mem_sel_o, mem_addr_o}), 32'({1'b1, 16'(i - 1)}));
        end
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        tick();
        chk("burst_last_addr", 32'({mem_sel_o, mem_addr_o}), 32'h13FFF);
        chk("burst_last_data", 32'(mem_data_o), 32'hF00F);
        tick();
        chk("burst_idle", 32'(mem_sel_o), 32'd0);
        chk("burst_ovf",  32'(overflow_o), 32'd0);
        chk("burst_maxlvl", 32'(maxlvl), 32'd2);

        // Overflow: 20 writes with ack held low
        mem_ack_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr(1'b1, 16'(16'h0200 + i), 16'(16'hB000 + i), 4'hF);
            tick();
            if (i == 15) begin
                chk("ovf_lvl16",  32'(level_o), 32'd16);
                chk("ovf_full",   32'(full_o), 32'd1);
                chk("ovf_before", 32'(overflow_o), 32'd0);
            end
            if (i == 16) begin
                chk("ovf_set",     32'(overflow_o), 32'd1);
                chk("ovf_lvl_hold", 32'(level_o), 32'd16);
            end
        end
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        chk("ovf_head", 32'({mem_sel_o, mem_addr_o}), 32'h10200);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        clear_overflow_i = 1'b1;
        tick();
        clear_overflow_i = 1'b0;
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        // Push and pop at the same edge while full
        mem_ack_i = 1'b1;
        wr(1'b1, 16'h0100, 16'h1234, 4'h3);
        tick();
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        chk("pp_lvl",  32'(level_o), 32'd16);
        chk("pp_ovf",  32'(overflow_o), 32'd0);
        chk("pp_addr", 32'(mem_addr_o), 32'h0201);
        for (int j = 2; j < 16; j++) begin
            tick();
            chk("drain_addr", 32'({mem_sel_o, mem_addr_o}), 32'({1'b1, 16'(16'h0200 + j)}));
        end
        chk("drain_data15", 32'(mem_data_o), 32'hB00F);
        tick();
        chk("drain_last_addr", 32'({mem_sel_o, mem_addr_o}), 32'h10100);
        chk("drain_last_data", 32'(mem_data_o), 32'h1234);
        chk("drain_last_mask", 32'(mem_mask_o), 32'h3);
        tick();
        chk("drain_idle",  32'(mem_sel_o), 32'd0);
        chk("drain_empty", 32'(empty_o), 32'd1);

        // Ack withheld mid-burst
        mem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(1'b1, 16'(16'h0300 + i), 16'(16'hA000 + i), 4'(i + 1));
            tick();
        end
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        chk("stall_head", 32'(mem_addr_o), 32'h0300);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("stall_second", 32'(mem_addr_o), 32'h0301);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_hold_addr", 32'({mem_sel_o, mem_addr_o}), 32'h10301);
            chk("stall_hold_dm",   32'({mem_data_o, mem_mask_o}), 32'hA0012);
        end
        mem_ack_i = 1'b1;
        tick();
        chk("stall_next_addr", 32'(mem_addr_o), 32'h0302);
        chk("stall_next_data", 32'(mem_data_o), 32'hA002);
        tick();
        mem_ack_i = 1'b0;
        chk("stall_idle",  32'(mem_sel_o), 32'd0);
        chk("stall_empty", 32'(empty_o), 32'd1);

        // Clear coinciding with a drop
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 16'(16'h0400 + i), 16'h0, 4'h0);
            tick();
        end
        chk("clr_full", 32'(full_o), 32'd1);
        wr(1'b1, 16'h04FF, 16'h0, 4'h0);
        clear_overflow_i = 1'b1;
        tick();
        clear_overflow_i = 1'b0;
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        chk("clr_vs_drop", 32'(overflow_o), 32'd1);
        clear_overflow_i = 1'b1;
        tick();
        clear_overflow_i = 1'b0;
        chk("clr_alone", 32'(overflow_o), 32'd0);

        // Asynchronous reset with 8 entries in flight
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, 16'(16'h0500 + i), 16'h0, 4'h0);
            tick();
        end
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        chk("ar_pre_lvl", 32'(level_o), 32'd8);
        chk("ar_pre_sel", 32'(mem_sel_o), 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("ar_sel", 32'(mem_sel_o), 32'd0);
        chk("ar_lvl", 32'(level_o), 32'd0);
        chk("ar_empty", 32'(empty_o), 32'd1);
        tick();
        reset_i = 1'b0;
        mem_ack_i = 1'b1;
        wr(1'b1, 16'h0555, 16'h5A5A, 4'hF);
        tick();
        wr(1'b0, 16'h0, 16'h0, 4'h0);
        chk("ar_new_lvl", 32'(level_o), 32'd1);
        tick();
        chk("ar_new_addr", 32'({mem_sel_o, mem_addr_o}), 32'h10555);
        chk("ar_new_data", 32'(mem_data_o), 32'h5A5A);
        tick();
        chk("ar_alone_sel", 32'(mem_sel_o), 32'd0);
        chk("ar_alone_lvl", 32'(level_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
